adder_arb: RTL

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb_pkg.sv | 23 ++
 rtl/adder_arb_rr.sv | 64 ++++++
 rtl/adder_arb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants and types for the adder_arb block.
//   DEF_DW   : default operand/sum width
//   CNT_W    : width of the optional statistics counters
//   rsp_t    : packed response {data, carry, id} at the default configuration
//   sat_inc  : saturating increment for statistics counters
package adder_arb_pkg;

    localparam int unsigned DEF_DW   = 32;
    localparam int unsigned DEF_ID_W = 2;
    localparam int unsigned CNT_W    = 16;

    typedef struct packed {
        logic [DEF_DW-1:0]   data;
        logic                carry;
        logic [DEF_ID_W-1:0] id;
    } rsp_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/adder_arb_rr.sv
// rr_arbiter: round-robin arbiter owning the priority pointer.
//   clk, rst      : clock, synchronous active-high reset
//   req_i         : request vector
//   advance_i     : strobe; moves the pointer past the current winner
//   grant_o       : one-hot grant (combinational), zero when no request
//   grant_idx_o   : index of the granted requester (combinational)
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_i,
    input  logic           advance_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o
);

    localparam int unsigned SW = IDW + 1;

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [SW-1:0]  pos;
    logic [IDW-1:0] idx;
    logic           found;

    // First asserted request at or after ptr_q, wrapping N-1 -> 0.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        pos         = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = SW'(ptr_q) + SW'(k);
            if (pos >= SW'(N)) begin
                pos = pos - SW'(N);
            end
            idx = pos[IDW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

    // Next pointer is one past the winner, modulo N.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (grant_idx_o == IDW'(N - 1)) ? '0 : grant_idx_o + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_arb.sv
// adder_arb: NUM_REQ requesters share one adder through a round-robin
// arbiter; the sum is registered with one cycle of latency behind a
// valid/ready response slot.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : per-requester handshake (req_ready is combinational)
//   req_a, req_b    : flattened operands, requester i at [i*DW +: DW]
//   rsp_valid/ready : response handshake
//   rsp_data/carry  : registered sum and carry-out
//   rsp_id          : requester that owns the response
// Optional build macro ADDER_ARB_STATS_EN adds grant_cnt (per-requester
// transfer counts, flattened) and stall_cnt (cycles with a request but no
// transfer); both saturate and are cleared by rst.
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = DEF_DW,
    localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DW-1:0]    req_a,
    input  logic [NUM_REQ*DW-1:0]    req_b,
    input  logic                     rsp_ready,
    output logic                     rsp_valid,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_carry,
`ifdef ADDER_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
`endif
    output logic [IDW-1:0]           rsp_id
);

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           carry;
        logic [IDW-1:0] id;
    } rsp_q_t;

    logic [NUM_REQ-1:0] grant_c;
    logic [IDW-1:0]     grant_idx_c;
    logic               slot_free_c;
    logic               transfer_c;
    logic [DW-1:0]      a_sel_c;
    logic [DW-1:0]      b_sel_c;
    logic [DW:0]        sum_c;

    rsp_q_t rsp_q, rsp_d;
    logic   rsp_valid_q, rsp_valid_d;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid),
        .advance_i   (transfer_c),
        .grant_o     (grant_c),
        .grant_idx_o (grant_idx_c)
    );

    // Slot is free when empty or being drained this cycle; depends only on
    // registered state and rsp_ready, so no loop through rsp_*.
    assign slot_free_c = !rsp_valid_q || rsp_ready;
    assign req_ready   = (rst || !slot_free_c) ? '0 : grant_c;
    assign transfer_c  = |req_ready;

    // One-hot operand select.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                a_sel_c = a_sel_c | req_a[i*DW +: DW];
                b_sel_c = b_sel_c | req_b[i*DW +: DW];
            end
        end
    end

    assign sum_c = {1'b0, a_sel_c} + {1'b0, b_sel_c};

    // Load on transfer (covers back-to-back), clear valid on drain, else hold.
    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        if (transfer_c) begin
            rsp_valid_d = 1'b1;
            rsp_d.data  = sum_c[DW-1:0];
            rsp_d.carry = sum_c[DW];
            rsp_d.id    = grant_idx_c;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_carry = rsp_q.carry;
    assign rsp_id    = rsp_q.id;

`ifdef ADDER_ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0] grant_cnt_q;
    logic [CNT_W-1:0]         stall_cnt_q;

    // Per-requester transfer counts and stall-cycle count, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    grant_cnt_q[i*CNT_W +: CNT_W] <= sat_inc(grant_cnt_q[i*CNT_W +: CNT_W]);
                end
            end
            if (|req_valid && !transfer_c) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
